// File: rtl/aes128_type_pkg.sv
// -----------------------------------------------------------------------------
// aes128_type_pkg
// Shared types and constants for the TinyQV AES-128 peripheral.
//   mode_t          : operation direction, latched per operation
//   round_phase_e   : phases of the iterative round sequencer
//   AES128_NUM_ROUNDS / AES128_NUM_BYTES : AES-128 geometry
// -----------------------------------------------------------------------------
package aes128_type_pkg;

   typedef enum logic {
      ENCRYPT = 1'b0,
      DECRYPT = 1'b1
   } mode_t;

   localparam int AES128_NUM_ROUNDS = 10;
   localparam int AES128_NUM_BYTES  = 16;

   typedef enum logic [3:0] {
      PH_IDLE   = 4'd0,
      PH_LOAD   = 4'd1,
      PH_KEYPRE = 4'd2,
      PH_ARK0   = 4'd3,
      PH_SHIFT  = 4'd4,
      PH_SUB    = 4'd5,
      PH_KEY    = 4'd6,
      PH_MIXARK = 4'd7,
      PH_DONE   = 4'd8
   } round_phase_e;

endpackage

// File: rtl/aes128_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes128_round_ctrl
// Iterative AES-128 round sequencer. Owns the phase FSM, the round counter and
// a shared step counter (S-box lane / pre-schedule step) and drives the Moore
// control strobes of the shared state/key datapath.
//
// Handshake: an operation is accepted on a clock edge where start_i=1 and
// ready_o=1 (IDLE). start_i at any other time is ignored. done_o pulses for one
// cycle when the result is valid; abort_i (any state except IDLE) returns to
// IDLE on the next edge with no done_o and has priority over every transition.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start_i, mode_i : operation request and direction (latched on accept)
//   abort_i         : cancel the operation in progress
//   ready_o, busy_o, done_o, mode_o : status and latched mode
//   data_load_o, ark_only_o, shift_en_o, sbox_en_o, key_step_o, mix_ark_en_o :
//                     datapath strobes, exactly one active per working cycle
//   sbox_lane_o     : lane being substituted (0 when not in SubBytes)
//   key_fwd_o, rcon_idx_o : key schedule direction and rcon index (0 unused)
//   skip_mix_o      : qualifies mix_ark_en_o in the final round (ARK only)
//   round_o         : current round 0..10
//   state_o         : current phase, for observation
// -----------------------------------------------------------------------------
module aes128_round_ctrl
   import aes128_type_pkg::*;
#(
   parameter int SBOX_LANES = 4,
   parameter int LANE_W     = ((AES128_NUM_BYTES / SBOX_LANES) > 1) ?
                              $clog2(AES128_NUM_BYTES / SBOX_LANES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  mode_t             mode_i,
   input  logic              abort_i,
   output logic              ready_o,
   output logic              busy_o,
   output logic              done_o,
   output mode_t             mode_o,
   output logic              data_load_o,
   output logic              ark_only_o,
   output logic              shift_en_o,
   output logic              sbox_en_o,
   output logic [LANE_W-1:0] sbox_lane_o,
   output logic              key_step_o,
   output logic              key_fwd_o,
   output logic [3:0]        rcon_idx_o,
   output logic              mix_ark_en_o,
   output logic              skip_mix_o,
   output logic [3:0]        round_o,
   output round_phase_e      state_o
);

   localparam int         NSUB        = AES128_NUM_BYTES / SBOX_LANES;
   localparam logic [3:0] LAST_SUB    = 4'(NSUB - 1);
   localparam logic [3:0] LAST_PRE    = 4'(AES128_NUM_ROUNDS - 1);
   localparam logic [3:0] LAST_ROUND  = 4'(AES128_NUM_ROUNDS);
   localparam logic [3:0] RCON_MIRROR = 4'(AES128_NUM_ROUNDS + 1);

   round_phase_e state_q, state_d;
   mode_t        mode_q, mode_d;
   logic [3:0]   round_q, round_d;
   // Step counter: S-box lane in SUB, pre-schedule step in KEYPRE.
   logic [3:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PH_IDLE;
         mode_q  <= ENCRYPT;
         round_q <= 4'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         round_q <= round_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      round_d      = round_q;
      cnt_d        = cnt_q;
      ready_o      = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      data_load_o  = 1'b0;
      ark_only_o   = 1'b0;
      shift_en_o   = 1'b0;
      sbox_en_o    = 1'b0;
      sbox_lane_o  = '0;
      key_step_o   = 1'b0;
      key_fwd_o    = 1'b0;
      rcon_idx_o   = 4'd0;
      mix_ark_en_o = 1'b0;
      skip_mix_o   = 1'b0;

      case (state_q)
         PH_IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               state_d = PH_LOAD;
               mode_d  = mode_i;
               round_d = 4'd0;
               cnt_d   = 4'd0;
            end
         end
         PH_LOAD: begin
            busy_o      = 1'b1;
            data_load_o = 1'b1;
            cnt_d       = 4'd0;
            // Decrypt needs the last round key first: run the schedule forward.
            state_d     = (mode_q == ENCRYPT) ? PH_ARK0 : PH_KEYPRE;
         end
         PH_KEYPRE: begin
            busy_o     = 1'b1;
            key_step_o = 1'b1;
            key_fwd_o  = 1'b1;
            rcon_idx_o = cnt_q + 4'd1;
            if (cnt_q == LAST_PRE) begin
               cnt_d   = 4'd0;
               state_d = PH_ARK0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         PH_ARK0: begin
            busy_o     = 1'b1;
            ark_only_o = 1'b1;
            round_d    = 4'd1;
            state_d    = PH_SHIFT;
         end
         PH_SHIFT: begin
            busy_o     = 1'b1;
            shift_en_o = 1'b1;
            cnt_d      = 4'd0;
            state_d    = PH_SUB;
         end
         PH_SUB: begin
            busy_o      = 1'b1;
            sbox_en_o   = 1'b1;
            sbox_lane_o = cnt_q[LANE_W-1:0];
            if (cnt_q == LAST_SUB) begin
               cnt_d   = 4'd0;
               state_d = PH_KEY;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         PH_KEY: begin
            busy_o     = 1'b1;
            key_step_o = 1'b1;
            key_fwd_o  = (mode_q == ENCRYPT);
            // Inverse schedule walks the rcon sequence backwards.
            rcon_idx_o = (mode_q == ENCRYPT) ? round_q : (RCON_MIRROR - round_q);
            state_d    = PH_MIXARK;
         end
         PH_MIXARK: begin
            busy_o       = 1'b1;
            mix_ark_en_o = 1'b1;
            skip_mix_o   = (round_q == LAST_ROUND);
            if (round_q == LAST_ROUND) begin
               state_d = PH_DONE;
            end else begin
               round_d = round_q + 4'd1;
               state_d = PH_SHIFT;
            end
         end
         PH_DONE: begin
            done_o  = 1'b1;
            state_d = PH_IDLE;
         end
         default: begin
            state_d = PH_IDLE;
            round_d = 4'd0;
            cnt_d   = 4'd0;
         end
      endcase

      if (abort_i && (state_q != PH_IDLE)) begin
         state_d = PH_IDLE;
         round_d = 4'd0;
         cnt_d   = 4'd0;
      end
   end

   assign mode_o  = mode_q;
   assign round_o = round_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;
   import aes128_type_pkg::*;

   localparam int W = 23;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT A: 4 lanes ----------------
   logic start_a = 1'b0, abort_a = 1'b0;
   mode_t mode_in_a = ENCRYPT, mode_a;
   logic ready_a, busy_a, done_a, load_a, ark_a, shift_a, sbox_a, key_a, fwd_a, mix_a, skip_a;
   logic [1:0] lane_a;
   logic [3:0] rcon_a, round_a;
   round_phase_e state_a;

   aes128_round_ctrl #(.SBOX_LANES(4)) dut_a (
      .clk(clk), .rst(rst), .start_i(start_a), .mode_i(mode_in_a), .abort_i(abort_a),
      .ready_o(ready_a), .busy_o(busy_a), .done_o(done_a), .mode_o(mode_a),
      .data_load_o(load_a), .ark_only_o(ark_a), .shift_en_o(shift_a),
      .sbox_en_o(sbox_a), .sbox_lane_o(lane_a), .key_step_o(key_a),
      .key_fwd_o(fwd_a), .rcon_idx_o(rcon_a), .mix_ark_en_o(mix_a),
      .skip_mix_o(skip_a), .round_o(round_a), .state_o(state_a)
   );

   // ---------------- DUT B: 16 lanes ----------------
   logic start_b = 1'b0, abort_b = 1'b0;
   mode_t mode_in_b = ENCRYPT, mode_b;
   logic ready_b, busy_b, done_b, load_b, ark_b, shift_b, sbox_b, key_b, fwd_b, mix_b, skip_b;
   logic [0:0] lane_b;
   logic [3:0] rcon_b, round_b;
   round_phase_e state_b;

   aes128_round_ctrl #(.SBOX_LANES(16)) dut_b (
      .clk(clk), .rst(rst), .start_i(start_b), .mode_i(mode_in_b), .abort_i(abort_b),
      .ready_o(ready_b), .busy_o(busy_b), .done_o(done_b), .mode_o(mode_b),
      .data_load_o(load_b), .ark_only_o(ark_b), .shift_en_o(shift_b),
      .sbox_en_o(sbox_b), .sbox_lane_o(lane_b), .key_step_o(key_b),
      .key_fwd_o(fwd_b), .rcon_idx_o(rcon_b), .mix_ark_en_o(mix_b),
      .skip_mix_o(skip_b), .round_o(round_b), .state_o(state_b)
   );

   // Observed vector: ready busy done load ark shift sbox lane[4] key fwd rcon[4] mix skip round[4]
   logic [W-1:0] obs_a, obs_b;
   assign obs_a = {ready_a, busy_a, done_a, load_a, ark_a, shift_a, sbox_a, 4'(lane_a),
                   key_a, fwd_a, rcon_a, mix_a, skip_a, round_a};
   assign obs_b = {ready_b, busy_b, done_b, load_b, ark_b, shift_b, sbox_b, 4'(lane_b),
                   key_b, fwd_b, rcon_b, mix_b, skip_b, round_b};

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] vec(input int ready, input int busy, input int done,
                                        input int load, input int ark, input int shift,
                                        input int sbox, input int lane, input int key,
                                        input int fwd, input int rcon, input int mix,
                                        input int skip, input int round);
      return {1'(ready), 1'(busy), 1'(done), 1'(load), 1'(ark), 1'(shift), 1'(sbox),
              4'(lane), 1'(key), 1'(fwd), 4'(rcon), 1'(mix), 1'(skip), 4'(round)};
   endfunction

   function automatic logic [W-1:0] idle_vec(input int round);
      return vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, round);
   endfunction

   // Expected per-cycle outputs from cycle 1 (after accept) through the done cycle.
   task automatic build_trace(input mode_t m, input int nsub);
      int enc;
      enc = (m == ENCRYPT) ? 1 : 0;
      exp_q.push_back(vec(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (!enc)
         for (int k = 1; k <= 10; k++)
            exp_q.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, k, 0, 0, 0));
      exp_q.push_back(vec(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int r = 1; r <= 10; r++) begin
         exp_q.push_back(vec(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, r));
         for (int l = 0; l < nsub; l++)
            exp_q.push_back(vec(0, 1, 0, 0, 0, 0, 1, l, 0, 0, 0, 0, 0, r));
         exp_q.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 1, enc, enc ? r : 11 - r, 0, 0, r));
         exp_q.push_back(vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, (r == 10) ? 1 : 0, r));
      end
      exp_q.push_back(vec(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
   endtask

   function automatic int op_len(input mode_t m, input int nsub);
      return 3 + ((m == DECRYPT) ? 10 : 0) + 10 * (nsub + 3);
   endfunction

   // ---------------- driver helpers ----------------
   function automatic logic [W-1:0] get_obs(input int sel);
      return (sel != 0) ? obs_b : obs_a;
   endfunction

   function automatic mode_t get_mode(input int sel);
      return (sel != 0) ? mode_b : mode_a;
   endfunction

   task automatic drive(input int sel, input logic start, input logic abort, input mode_t m);
      if (sel != 0) begin start_b = start; abort_b = abort; mode_in_b = m; end
      else begin start_a = start; abort_a = abort; mode_in_a = m; end
   endtask

   // One operation; abort_at > 0 aborts after the sample of that cycle.
   task automatic run_op(input int sel, input mode_t m, input int abort_at, output int done_cyc);
      int n;
      logic [W-1:0] exp;
      logic [W-1:0] got;
      done_cyc = -1;
      exp_q.delete();
      build_trace(m, (sel != 0) ? 1 : 4);
      n = exp_q.size();
      @(negedge clk);
      check("ready_before_start", 32'(get_obs(sel)[22]), 32'd1);
      drive(sel, 1'b1, 1'b0, m);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == 1) drive(sel, 1'b0, 1'b0, m);
         exp = exp_q.pop_front();
         got = get_obs(sel);
         if (got[20] && done_cyc < 0) done_cyc = k;
         check($sformatf("op%0d_m%0d_c%0d", sel, m, k), 32'(got), 32'(exp));
         check($sformatf("mode%0d_c%0d", sel, k), 32'(get_mode(sel)), 32'(m));
         if (k == abort_at) begin
            drive(sel, 1'b0, 1'b1, m);
            @(negedge clk);
            check($sformatf("abort%0d_c%0d", sel, k), 32'(get_obs(sel)), 32'(idle_vec(0)));
            drive(sel, 1'b0, 1'b0, m);
            @(negedge clk);
            check("abort_stays_idle", 32'(get_obs(sel)), 32'(idle_vec(0)));
            exp_q.delete();
            return;
         end
      end
      @(negedge clk);
      check($sformatf("idle_after%0d", sel), 32'(get_obs(sel)), 32'(idle_vec(10)));
   endtask

   // start_i held high across two back-to-back operations.
   task automatic run_held(input int sel, input mode_t m);
      int len1, n;
      logic [W-1:0] exp;
      exp_q.delete();
      build_trace(m, (sel != 0) ? 1 : 4);
      len1 = exp_q.size();
      exp_q.push_back(idle_vec(10));
      build_trace(m, (sel != 0) ? 1 : 4);
      exp_q.push_back(idle_vec(10));
      exp_q.push_back(idle_vec(10));
      n = exp_q.size();
      @(negedge clk);
      drive(sel, 1'b1, 1'b0, m);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (k == len1 + 2) drive(sel, 1'b0, 1'b0, m);
         exp = exp_q.pop_front();
         check($sformatf("held%0d_c%0d", sel, k), 32'(get_obs(sel)), 32'(exp));
      end
   endtask

   // ---------------- stimulus ----------------
   int dc;
   initial begin
      #2;
      check("rst_a", 32'(obs_a), 32'(idle_vec(0)));
      check("rst_b", 32'(obs_b), 32'(idle_vec(0)));
      check("rst_mode_a", 32'(mode_a), 32'(ENCRYPT));
      check("rst_state_a", 32'(state_a), 32'(PH_IDLE));
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;

      // Directed latency checks
      run_op(0, ENCRYPT, -1, dc); check("done_enc4", 32'(dc), 32'd73);
      run_op(0, DECRYPT, -1, dc); check("done_dec4", 32'(dc), 32'd83);
      run_op(1, ENCRYPT, -1, dc); check("done_enc16", 32'(dc), 32'd43);
      run_op(1, DECRYPT, -1, dc); check("done_dec16", 32'(dc), 32'd53);

      // Abort in round 5, SUB lane 2 (cycle 34), then a clean encrypt
      run_op(0, ENCRYPT, 34, dc); check("abort_no_done", 32'(dc), 32'hffffffff);
      run_op(0, ENCRYPT, -1, dc); check("done_after_abort", 32'(dc), 32'd73);

      // Held start
      run_held(0, ENCRYPT);
      run_held(1, DECRYPT);

      // Randomized operations with occasional aborts and idle gaps
      for (int i = 0; i < 24; i++) begin
         int sel, ab, n;
         mode_t m;
         sel = $urandom_range(0, 1);
         m = mode_t'($urandom_range(0, 1));
         n = op_len(m, (sel != 0) ? 1 : 4);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : -1;
         run_op(sel, m, ab, dc);
         if (ab < 0) check("rand_done", 32'(dc), 32'(n));
         else check("rand_abort_no_done", 32'(dc), 32'hffffffff);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Asynchronous reset in the middle of KEYPRE
      @(negedge clk);
      drive(0, 1'b1, 1'b0, DECRYPT);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, DECRYPT);
      repeat (4) @(negedge clk);
      check("pre_rst_keypre", 32'(obs_a[11]), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_a", 32'(obs_a), 32'(idle_vec(0)));
      check("async_rst_b", 32'(obs_b), 32'(idle_vec(0)));
      check("async_rst_mode", 32'(mode_a), 32'(ENCRYPT));
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 32'(obs_a), 32'(idle_vec(0)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
